comp_serial_lsb: RTL and testbench

//  Sequential magnitude comparator that scans operands LSB-digit first, one DIGIT-bit slice per clock.

---
 rtl/comp_serial_lsb_if.sv | 16 +
 rtl/comp_serial_lsb.sv | 110 +++++++++++
 tb/tb_comp_serial_lsb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/comp_serial_lsb_if.sv
// Start/done handshake, operands and one-hot verdict flags of the serial LSB-first comparator.
interface comp_serial_lsb_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_G_B;
    logic             A_E_B;
    logic             A_L_B;

    modport master (output start, A, B, input busy, done, A_G_B, A_E_B, A_L_B);
    modport slave  (input start, A, B, output busy, done, A_G_B, A_E_B, A_L_B);
endinterface

// File: rtl/comp_serial_lsb.sv
// Serial magnitude comparator: one DIGIT-bit slice per clock, LSB digit first.
// Define SIGNED_CMP_EN for two's-complement operands (MSD top bit inverted before compare).
module comp_serial_lsb #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    comp_serial_lsb_if.slave      bus
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic { S_IDLE, S_RUN } state_t;
    typedef enum logic [1:0] { REL_EQ, REL_GT, REL_LT } rel_t;

    state_t           r_state, w_state_nx;
    rel_t             r_rel, w_rel_nx, w_rel_upd;
    logic [WIDTH-1:0] r_a, r_b, w_a_nx, w_b_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_done, w_done_nx;
    logic             r_gt, r_eq, r_lt, w_gt_nx, w_eq_nx, w_lt_nx;
    logic [DIGIT-1:0] w_da, w_db;
    logic             w_last;

    assign w_last = (r_cnt == CW'(NUM_DIGITS - 1));

    // A higher digit that differs overrides whatever the lower digits decided.
    always_comb begin
        w_da = r_a[DIGIT-1:0];
        w_db = r_b[DIGIT-1:0];
`ifdef SIGNED_CMP_EN
        if (w_last) begin
            w_da[DIGIT-1] = ~w_da[DIGIT-1];
            w_db[DIGIT-1] = ~w_db[DIGIT-1];
        end
`else
`endif
        if (w_da > w_db)      w_rel_upd = REL_GT;
        else if (w_da < w_db) w_rel_upd = REL_LT;
        else                  w_rel_upd = r_rel;
    end

    always_comb begin
        w_state_nx = r_state;
        w_rel_nx   = r_rel;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_cnt_nx   = r_cnt;
        w_done_nx  = 1'b0;
        w_gt_nx    = r_gt;
        w_eq_nx    = r_eq;
        w_lt_nx    = r_lt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nx = S_RUN;
                    w_a_nx     = bus.A;
                    w_b_nx     = bus.B;
                    w_rel_nx   = REL_EQ;
                    w_cnt_nx   = '0;
                end
            end
            S_RUN: begin
                w_a_nx   = r_a >> DIGIT;
                w_b_nx   = r_b >> DIGIT;
                w_rel_nx = w_rel_upd;
                w_cnt_nx = r_cnt + 1'b1;
                if (w_last) begin
                    w_state_nx = S_IDLE;
                    w_done_nx  = 1'b1;
                    w_gt_nx    = (w_rel_upd == REL_GT);
                    w_eq_nx    = (w_rel_upd == REL_EQ);
                    w_lt_nx    = (w_rel_upd == REL_LT);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rel   <= REL_EQ;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rel   <= w_rel_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
            r_gt    <= w_gt_nx;
            r_eq    <= w_eq_nx;
            r_lt    <= w_lt_nx;
        end
    end

    assign bus.busy  = (r_state == S_RUN);
    assign bus.done  = r_done;
    assign bus.A_G_B = r_gt;
    assign bus.A_E_B = r_eq;
    assign bus.A_L_B = r_lt;
endmodule

// File: tb/tb_comp_serial_lsb.sv
// Directed bench for comp_serial_lsb: expected verdicts queued at start, checked at done.
module tb_comp_serial_lsb;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int ND    = WIDTH / DIGIT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    comp_serial_lsb_if #(.WIDTH(WIDTH)) ifc ();
    comp_serial_lsb #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // {gt, eq, lt}
    function automatic logic [2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SIGNED_CMP_EN
        if ($signed(a) > $signed(b)) return 3'b100;
        if ($signed(a) < $signed(b)) return 3'b001;
`else
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
`endif
        return 3'b010;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {ifc.A_G_B, ifc.A_E_B, ifc.A_L_B};
    endfunction

    // Drive a pair, queue its verdict, and return #1 after the accepting edge.
    task automatic start_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        ifc.A = a; ifc.B = b; ifc.start = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("busy_after_start", 32'(ifc.busy), 32'd1);
    endtask

    // Count edges until done; compare latency and the queued verdict.
    task automatic wait_done(input string tag, input int lat);
        int n = 0;
        logic [2:0] e;
        do begin
            @(posedge clk); #1; n++;
        end while (!ifc.done && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            if (ifc.done) begin
                chk({tag, "_flags"}, 32'(flags()), 32'(e));
                chk({tag, "_busy_at_done"}, 32'(ifc.busy), 32'd0);
            end
        end
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ifc.done) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] pa[6];
        logic [WIDTH-1:0] pb[6];
        ifc.start = 1'b0; ifc.A = '0; ifc.B = '0;

        #12;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: equal operands, done one cycle only, flags hold afterwards
        start_cmp(16'h1234, 16'h1234);
        ifc.A = 16'hFFFF; ifc.B = 16'h0000;
        wait_done("t1", ND);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(ifc.done), 32'd0);
        chk("t1_flags_hold", 32'(flags()), 32'b010);

        // 2: upper digit overrides lower digit
        start_cmp(16'h0001, 16'h0100);
        wait_done("t2", ND);

        // 3: sign boundary
        start_cmp(16'h8000, 16'h7FFF);
        wait_done("t3", ND);

        // 4: start held through busy; accepted in the done cycle
        start_cmp(16'hFFFF, 16'h0000);
        ifc.A = 16'h0000; ifc.B = 16'hFFFF; ifc.start = 1'b1;
        exp_q.push_back(model(16'h0000, 16'hFFFF));
        wait_done("t4a", ND);
        @(posedge clk); #1;
        ifc.start = 1'b0;
        chk("t4_busy_accept", 32'(ifc.busy), 32'd1);
        wait_done("t4b", ND);
        no_done("t4_no_extra_done", 6);

        // 5: reset two cycles into a run aborts at once
        start_cmp(16'hFFFF, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("t5_busy", 32'(ifc.busy), 32'd0);
        chk("t5_done", 32'(ifc.done), 32'd0);
        chk("t5_flags", 32'(flags()), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        no_done("t5_no_done_after_abort", 8);
        start_cmp(16'd5, 16'd3);
        wait_done("t5b", ND);

        // 6: back-to-back, start never drops; each done starts the next pair
        pa[0] = 16'h8000; pb[0] = 16'h0000;
        pa[1] = 16'h0F00; pb[1] = 16'h0F00;
        for (int i = 2; i < 6; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = (i == 3) ? pa[i] ^ 16'h0010 : 16'($urandom);
        end
        @(negedge clk);
        ifc.A = pa[0]; ifc.B = pb[0]; ifc.start = 1'b1;
        exp_q.push_back(model(pa[0], pb[0]));
        for (int i = 0; i < 6; i++) begin
            wait_done("t6", ND + 1);
            if (i < 5) begin
                ifc.A = pa[i+1]; ifc.B = pb[i+1];
                exp_q.push_back(model(pa[i+1], pb[i+1]));
            end else begin
                ifc.start = 1'b0;
            end
        end
        no_done("t6_idle_after", 8);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
